// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: analyzer FSM states, default polynomial and the
// MISR single-step function used by the RTL and by reference models.
package lbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] LBIST_POLY8 = 8'hB8;

    // One Galois MISR step on values held in the low bits of 64-bit words.
    // Callers zero-extend sig/resp/poly and truncate the result back to their
    // width. The upper bits then stay zero, so this works for any width up to 64.
    function automatic logic [63:0] misr_step(input logic [63:0] sig,
                                              input logic [63:0] resp,
                                              input logic [63:0] poly);
        misr_step = ((sig >> 1) ^ (sig[0] ? poly : 64'd0)) ^ resp;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register with Galois feedback and optional X-masking.
// Optional feature: define MISR_XMASK_EN to add the mask port (masked bits compact as 0).
module misr_core
    import lbist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = LBIST_POLY8,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [0:WIDTH-1] resp,
`ifdef MISR_XMASK_EN
    input  logic [0:WIDTH-1] mask,
`endif
    output logic [0:WIDTH-1] sig
);

    // Index 0 is the MSB, so these vectors carry the same numeric value as a
    // [WIDTH-1:0] vector; the step function works on that numeric value.
    logic [0:WIDTH-1] resp_eff;

`ifdef MISR_XMASK_EN
    // Masked response bits contribute nothing to the signature.
    always_comb resp_eff = resp & ~mask;
`else
    // Without masking the response is compacted as-is.
    always_comb resp_eff = resp;
`endif

    // Signature register: seed on reset/load, one Galois step per accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (step) begin
            sig <= WIDTH'(misr_step(64'(sig), 64'(resp_eff), 64'(POLY)));
        end
    end

endmodule

// File: rtl/misr_analyzer.sv
// LBIST response analyzer: runs NUM_PATTERNS responses through the MISR,
// then compares the final signature against GOLDEN.
// Optional feature: define MISR_XMASK_EN to add the mask port.
module misr_analyzer
    import lbist_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] POLY         = LBIST_POLY8,
    parameter logic [WIDTH-1:0] SEED         = '0,
    parameter int               NUM_PATTERNS = 16,
    parameter logic [WIDTH-1:0] GOLDEN       = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic [0:WIDTH-1] resp,
`ifdef MISR_XMASK_EN
    input  logic [0:WIDTH-1] mask,
`endif
    output logic [0:WIDTH-1] signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int             CW   = $clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0]  LAST = CW'(NUM_PATTERNS - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic          load;
    logic          step;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the load/step strobes for the signature register.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_COMPACT;
                end
            end
            ST_COMPACT: begin
                if (en) begin
                    step = 1'b1;
                    // Leave on the final response, so the count never wraps.
                    if (count == LAST) begin
                        state_nxt = ST_COMPARE;
                    end
                end
            end
            ST_COMPARE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Count of responses accepted in the current run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + CW'(1);
        end
    end

    // Pass flag: cleared at the start of a run and set once in COMPARE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (load) begin
            pass <= 1'b0;
        end else if (state == ST_COMPARE) begin
            pass <= (signature == GOLDEN);
        end
    end

    // Status flags decode the state register only, so inputs cannot reach them combinationally.
    always_comb begin
        busy = (state == ST_COMPACT) || (state == ST_COMPARE);
        done = (state == ST_DONE);
    end

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .resp  (resp),
`ifdef MISR_XMASK_EN
        .mask  (mask),
`endif
        .sig   (signature)
    );

endmodule

// File: tb/tb_misr_analyzer.sv
// Directed bench for misr_analyzer: short golden runs, a gapped 16-pattern
// run, restart from DONE, asynchronous mid-run reset and (with MISR_XMASK_EN) full masking.
module tb_misr_analyzer;
    import lbist_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    int         errors = 0;
    int         checks = 0;

    // Shared stimulus for the two NUM_PATTERNS=2 instances.
    logic       start_ab, en_ab;
    logic [0:7] resp_ab;
    logic [0:7] sig_a, sig_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;

    // Stimulus for the NUM_PATTERNS=16 instance.
    logic       start_c, en_c;
    logic [0:7] resp_c;
    logic [0:7] sig_c;
    logic       busy_c, done_c, pass_c;

`ifdef MISR_XMASK_EN
    logic [0:7] mask_ab = 8'h00;
    logic [0:7] mask_c  = 8'h00;
`endif

    misr_analyzer #(.WIDTH(8), .NUM_PATTERNS(2), .GOLDEN(8'hBA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_ab), .en(en_ab), .resp(resp_ab),
`ifdef MISR_XMASK_EN
        .mask(mask_ab),
`endif
        .signature(sig_a), .busy(busy_a), .done(done_a), .pass(pass_a));

    misr_analyzer #(.WIDTH(8), .NUM_PATTERNS(2), .GOLDEN(8'hBB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_ab), .en(en_ab), .resp(resp_ab),
`ifdef MISR_XMASK_EN
        .mask(mask_ab),
`endif
        .signature(sig_b), .busy(busy_b), .done(done_b), .pass(pass_b));

    misr_analyzer #(.WIDTH(8), .NUM_PATTERNS(16), .GOLDEN(8'h00)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .en(en_c), .resp(resp_c),
`ifdef MISR_XMASK_EN
        .mask(mask_c),
`endif
        .signature(sig_c), .busy(busy_c), .done(done_c), .pass(pass_c));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] r);
        return 8'(misr_step(64'(s), 64'(r), 64'(LBIST_POLY8)));
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; start_ab = 0; en_ab = 0; resp_ab = 0;
        start_c = 0; en_c = 0; resp_c = 0;
        #12;
        checks++; if (sig_a !== 8'h00) begin errors++; $display("FAIL reset_sig_a: got %h expected 00", sig_a); end
        checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin errors++; $display("FAIL reset_flags_a: got %b expected 000", {busy_a, done_a, pass_a}); end
        checks++; if (sig_c !== 8'h00) begin errors++; $display("FAIL reset_sig_c: got %h expected 00", sig_c); end
        checks++; if ({busy_c, done_c, pass_c} !== 3'b000) begin errors++; $display("FAIL reset_flags_c: got %b expected 000", {busy_c, done_c, pass_c}); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_golden;
        start_ab = 1; tick; start_ab = 0;
        checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL start_busy: got busy=%b done=%b expected 1 0", busy_a, done_a); end
        en_ab = 1; resp_ab = 8'h01; tick;
        checks++; if (sig_a !== 8'h01) begin errors++; $display("FAIL mid_sig: got %h expected 01", sig_a); end
        resp_ab = 8'h02; tick;
        en_ab = 0; resp_ab = 8'h00;
        checks++; if (sig_a !== 8'hBA) begin errors++; $display("FAIL final_sig: got %h expected BA", sig_a); end
        checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL compare_state: got busy=%b done=%b expected 1 0", busy_a, done_a); end
        tick;
        checks++; if ({busy_a, done_a, pass_a} !== 3'b011) begin errors++; $display("FAIL done_pass_a: got %b expected 011", {busy_a, done_a, pass_a}); end
        checks++; if (sig_b !== 8'hBA || done_b !== 1'b1 || pass_b !== 1'b0) begin errors++; $display("FAIL done_fail_b: got sig=%h done=%b pass=%b expected BA 1 0", sig_b, done_b, pass_b); end
        // en outside COMPACT must leave the signature alone
        en_ab = 1; resp_ab = 8'hFF; tick; tick; en_ab = 0;
        checks++; if (sig_a !== 8'hBA || done_a !== 1'b1 || pass_a !== 1'b1) begin errors++; $display("FAIL done_hold: got sig=%h done=%b pass=%b expected BA 1 1", sig_a, done_a, pass_a); end
    endtask

    task automatic test_gapped;
        // en in IDLE is ignored
        en_c = 1; resp_c = 8'hAA; tick; en_c = 0; resp_c = 8'h00;
        checks++; if (sig_c !== 8'h00 || busy_c !== 1'b0) begin errors++; $display("FAIL idle_en: got sig=%h busy=%b expected 00 0", sig_c, busy_c); end
        start_c = 1; tick; start_c = 0;
        for (int i = 0; i < 16; i++) begin
            en_c = 1; tick; en_c = 0;
            if (i < 15) begin
                checks++; if (done_c !== 1'b0 || busy_c !== 1'b1 || sig_c !== 8'h00) begin errors++; $display("FAIL gapped_%0d: got done=%b busy=%b sig=%h expected 0 1 00", i, done_c, busy_c, sig_c); end
            end
            if (i == 5) start_c = 1;
            tick;
            start_c = 0;
            tick;
        end
        checks++; if ({busy_c, done_c, pass_c} !== 3'b011 || sig_c !== 8'h00) begin errors++; $display("FAIL gapped_done: got flags=%b sig=%h expected 011 00", {busy_c, done_c, pass_c}, sig_c); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] model;
        logic [7:0] r;
        model = 8'h00;
        start_c = 1; tick; start_c = 0;
        checks++; if (done_c !== 1'b0 || busy_c !== 1'b1 || sig_c !== 8'h00) begin errors++; $display("FAIL restart1: got done=%b busy=%b sig=%h expected 0 1 00", done_c, busy_c, sig_c); end
        for (int i = 0; i < 16; i++) begin
            r = 8'(i * 37 + 5);
            en_c = 1; resp_c = r; tick;
            model = ref_step(model, r);
        end
        en_c = 0; resp_c = 8'h00;
        checks++; if (done_c !== 1'b0 || busy_c !== 1'b1) begin errors++; $display("FAIL b2b_compare: got done=%b busy=%b expected 0 1", done_c, busy_c); end
        tick;
        checks++; if (sig_c !== model || done_c !== 1'b1 || pass_c !== (model == 8'h00)) begin errors++; $display("FAIL b2b_final: got sig=%h done=%b pass=%b expected %h 1 %b", sig_c, done_c, pass_c, model, (model == 8'h00)); end
        // second restart must reload SEED and drop done
        start_c = 1; tick; start_c = 0;
        checks++; if (sig_c !== 8'h00 || done_c !== 1'b0 || pass_c !== 1'b0) begin errors++; $display("FAIL restart2: got sig=%h done=%b pass=%b expected 00 0 0", sig_c, done_c, pass_c); end
    endtask

    task automatic test_midrun_reset;
        en_c = 1; resp_c = 8'h3C; tick; resp_c = 8'h5A; tick; en_c = 0;
        checks++; if (sig_c !== ref_step(8'h3C, 8'h5A)) begin errors++; $display("FAIL pre_reset_sig: got %h expected %h", sig_c, ref_step(8'h3C, 8'h5A)); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sig_c !== 8'h00 || {busy_c, done_c, pass_c} !== 3'b000) begin errors++; $display("FAIL async_reset: got sig=%h flags=%b expected 00 000", sig_c, {busy_c, done_c, pass_c}); end
        tick;
        rst_n = 1'b1;
        tick;
        checks++; if (busy_c !== 1'b0 || sig_c !== 8'h00) begin errors++; $display("FAIL after_reset: got busy=%b sig=%h expected 0 00", busy_c, sig_c); end
    endtask

`ifdef MISR_XMASK_EN
    task automatic test_mask;
        mask_c = 8'hFF;
        start_c = 1; tick; start_c = 0;
        for (int i = 0; i < 16; i++) begin
            en_c = 1; resp_c = 8'($urandom_range(1, 255)); tick;
        end
        en_c = 0; resp_c = 8'h00; tick;
        checks++; if (sig_c !== 8'h00 || done_c !== 1'b1 || pass_c !== 1'b1) begin errors++; $display("FAIL mask_all: got sig=%h done=%b pass=%b expected 00 1 1", sig_c, done_c, pass_c); end
        mask_c = 8'h00;
    endtask
`endif

    initial begin
        test_reset;
        test_golden;
        test_gapped;
        test_back_to_back;
        test_midrun_reset;
`ifdef MISR_XMASK_EN
        test_mask;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/misr_analyzer.md
# misr_analyzer

Response-side LBIST block: compacts a stream of circuit-under-test responses into a multiple-input signature register (MISR), counts accepted responses, and compares the final signature against a golden value. It is the receiving end of the stimulus path driven by the pattern counter. Each `en` pulse here corresponds to one `inc` pulse on the counter side, so both ends step in lockstep through the same pattern sequence.

## Interface
- `WIDTH`, 8: response and signature width in bits; matches the counter `BITS`.
- `POLY`, 8'hB8: Galois feedback polynomial; numeric value, WIDTH bits.
- `SEED`, 0: signature value loaded at reset and on start.
- `NUM_PATTERNS`, 16: responses compacted per run; must be ≥1.
- `GOLDEN`, 0: expected final signature.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled in IDLE or DONE.
- `en` in 1: response valid this cycle; sampled only in COMPACT.
- `resp` in [0:WIDTH-1]: CUT response word; index 0 is the MSB, as in the counter.
- `signature` out [0:WIDTH-1]: current MISR contents.
- `busy` out 1: high in COMPACT and COMPARE.
- `done` out 1: high in DONE.
- `pass` out 1: result of the comparison; valid while `done` is high.

## Operation
- FSM states: IDLE, COMPACT, COMPARE, DONE.
- IDLE, `start`=1: go to COMPACT; `signature`←SEED; count←0; `pass`←0.
- COMPACT, `en`=1: `signature` ← ((sig>>1) ^ (sig[LSB] ? POLY : 0)) ^ `resp`, using numeric shift with LSB = index WIDTH-1; count←count+1.
- COMPACT: on the cycle that accepts response number NUM_PATTERNS, go to COMPARE. `en`=0 holds both signature and count; there is no timeout.
- COMPARE: `pass` ← (`signature`==GOLDEN); go to DONE unconditionally.
- DONE: `done`, `pass` and `signature` hold. `start`=1 restarts exactly as from IDLE; `done` drops on the next edge.
- `start` in COMPACT or COMPARE is ignored.
- `en` in IDLE, COMPARE or DONE is ignored; signature and count are unchanged.
- Count width is $clog2(NUM_PATTERNS+1). The counter never wraps, because the transition leaves COMPACT at NUM_PATTERNS.

## Timing
- Reset values: state IDLE, `signature`=SEED, count 0, `busy` 0, `done` 0, `pass` 0. Reset applies immediately and asynchronously.
- Reset mid-run aborts the run with no partial result; the block returns to IDLE.
- `start` sampled at edge E: `busy`=1 after E; the first response can be accepted at edge E+1.
- Each response is compacted at the edge where `en`=1 is sampled; `signature` is visible one cycle later. Throughput is one response per cycle.
- Last response accepted at edge N: COMPARE after N; `done`=1 and `pass` valid after edge N+1; `busy`=0 after N+1.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- Macro `MISR_XMASK_EN` controls X-masking.
- Defined: adds port `mask` in [0:WIDTH-1]. The compacted value is `resp` & ~`mask`, so masked bits contribute 0 (used to exclude unknown or X-prone CUT outputs).
- Undefined: no `mask` port; `resp` is compacted unmodified.
- With `mask` tied to 0, signatures are identical in both builds.

## Structure
- Shared package `lbist_pkg` holds:
  - the typedef enum of the FSM states;
  - the default polynomial constant `LBIST_POLY8`=8'hB8;
  - a function computing one MISR step, so benches can build reference models.
- Sub-module `misr_core` contains the signature register, the Galois step and the optional mask. Ports: clk, rst_n, load, step, resp, (mask), sig.
- `misr_analyzer` contains the FSM, the pattern count and the compare.

## Test plan
- Reset, then no stimulus: `signature`=8'h00, `busy`/`done`/`pass`=0. Assert `rst_n` low mid-COMPACT: outputs return to reset values within the same cycle.
- NUM_PATTERNS=2, GOLDEN=8'hBA: `start`, then `resp` 8'h01, 8'h02 on consecutive `en` cycles. Intermediate `signature`=8'h01, final 8'hBA; `done`=1 and `pass`=1 one cycle after COMPARE.
- Same run with GOLDEN=8'hBB: `done`=1, `pass`=0, `signature`=8'hBA.
- NUM_PATTERNS=16 with `en` gapped (one cycle on, two off) and all `resp`=8'h00: signature stays 8'h00; `done` asserts only after the 16th `en`; `start` pulsed mid-run has no effect.
- From DONE, `start` again with a different response sequence: `done` drops next cycle, `signature` reloads SEED, and the new final value matches the `lbist_pkg` step model.
- `MISR_XMASK_EN` build: `mask`=8'hFF for the whole run with random `resp` gives final `signature`=8'h00. With `mask`=8'h00, results match the unmasked build bit-for-bit.
